// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// buffers one returned instruction when the pipeline is stalled, and drives
// the Fetch->Decode pipeline register.
//
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   StallF, StallD, FlushD hazard-unit controls
//   branch_D, jump_D       predicted-taken redirect from Decode
//   target_D               Decode redirect target
//   mispredict_E           Execute misprediction (wins over Decode redirect)
//   recover_pc_E           correct PC after a misprediction
//   imem_req, imem_addr    request strobe / address to instruction memory
//   imem_valid, imem_rdata in-order response from instruction memory
//   instr_D, pc_D,
//   pcplus4_D, valid_D     Decode register contents
//   fetch_wait             Decode could accept but nothing is available
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        branch_D,
    input  logic        jump_D,
    input  logic [31:0] target_D,
    input  logic        mispredict_E,
    input  logic [31:0] recover_pc_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pcplus4_D,
    output logic        valid_D,
    output logic        fetch_wait
);

    // IDLE: nothing outstanding; WAIT: request for pc_q in flight;
    // HELD: instruction for pc_q sits in instr_buf; DROP: stale request in flight.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_buf;
    logic        buf_load;

    logic        avail;
    logic        redirect;
    logic        consume;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] fetched;

    assign pc_plus4 = pc_q + 32'd4;   // modulo 2^32, wraps naturally
    assign avail    = ((state_q == S_WAIT) && imem_valid) || (state_q == S_HELD);
    assign redirect = mispredict_E || ((branch_D || jump_D) && !StallD);
    assign consume  = avail && !StallF && !StallD && !redirect;
    assign target   = mispredict_E ? recover_pc_E : target_D;
    assign fetched  = (state_q == S_HELD) ? instr_buf : imem_rdata;

    assign fetch_wait = !StallF && !StallD && !avail;

    // Request issue. A consume cycle immediately requests the next word so a
    // 1-cycle memory sustains one instruction per cycle.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (nreset) begin
            if ((state_q == S_IDLE) && !StallF && !redirect) begin
                imem_req = 1'b1;
            end else if (consume) begin
                imem_req  = 1'b1;
                imem_addr = pc_plus4;
            end
        end
    end

    // Next-state logic.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_load = 1'b0;
        if (redirect) begin
            pc_d = target;
            // A request still in flight must have its response swallowed
            // before the target may be requested.
            if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_valid)
                state_d = S_DROP;
            else
                state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (!StallF) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        if (consume) begin
                            pc_d = pc_plus4;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = S_HELD;
                        end
                    end
                end
                S_HELD: begin
                    if (consume) begin
                        pc_d    = pc_plus4;
                        state_d = S_WAIT;
                    end
                end
                S_DROP: if (imem_valid) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the buffer is data-only; the FSM says whether it is meaningful,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (buf_load) instr_buf <= imem_rdata;
    end

    // Fetch->Decode register: flush beats stall beats consume; anything else
    // is a bubble.
    always_ff @(posedge clk) begin
        if (!nreset || FlushD) begin
            instr_D   <= NOP_INSTR;
            pc_D      <= 32'd0;
            pcplus4_D <= 32'd0;
            valid_D   <= 1'b0;
        end else if (StallD) begin
            instr_D   <= instr_D;
            pc_D      <= pc_D;
            pcplus4_D <= pcplus4_D;
            valid_D   <= valid_D;
        end else if (consume) begin
            instr_D   <= fetched;
            pc_D      <= pc_q;
            pcplus4_D <= pc_plus4;
            valid_D   <= 1'b1;
        end else begin
            instr_D   <= NOP_INSTR;
            pc_D      <= 32'd0;
            pcplus4_D <= 32'd0;
            valid_D   <= 1'b0;
        end
    end

endmodule
